dilation3x3_stream: RTL and testbench
=====================================

Name: dilation3x3_stream

Overview:
- Streaming 3x3 morphological dilation, the dual of the erosion block. Each output bit is the OR of the masked 3x3 neighbourhood.
- Sits in the binary-mask pipeline after thresholding/erosion, feeding blob detection.
- Owns its line buffers, row/column counters and an end-of-frame flush engine.
- Emits exactly img_width*img_height output pixels per frame, with zero padding outside the image.

Parameters:
- N, 1, bits per pixel; each bit is dilated independently.
- MAX_WIDTH, 640, line-buffer depth; the largest supported img_width.
- MASK, 9'h1FF, structuring element; bit (3*r+c) enables window position k_rc, where r and c are 0..2 and 11 is the centre.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- img_width  in  16  frame width in pixels, 2..MAX_WIDTH; sampled on the first pixel of a frame.
- img_height  in  16  frame height in rows, >=2; sampled on the first pixel of a frame.
- in_valid  in  1  input pixel present.
- in_ready  out  1  block accepts input; a pixel transfers when in_valid and in_ready are both high.
- in_pixel  in  N  input pixel, raster order.
- out_valid  out  1  output pixel strobe, single cycle.
- out_pixel  out  N  dilated pixel, raster order.
- frame_done  out  1  one-cycle pulse with the last output pixel of a frame.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, out_pixel=0, frame_done=0. All counters and window registers are cleared. Line-buffer contents are don't-care because border masking covers them.
- Reset mid-frame aborts the frame. No further outputs come from that frame and no stale data appears in the next frame.
- States:
  - IDLE: on the first accepted pixel, latch W=img_width and H=img_height, then go to RUN.
  - RUN: on each accepted pixel, shift the window and line buffers and advance the input counter. After pixel W*H is accepted, go to FLUSH.
  - FLUSH: in_ready=0. Inject one virtual zero pixel per cycle, W+1 in total. After the last one, go to IDLE.
- Latency:
  - Output index j (row r, column c) is emitted one cycle after input index j+W+1 is accepted, or after the equivalent virtual pixel is injected.
  - The first W+1 accepted pixels produce no output.
  - Total outputs per frame = W*H.
  - frame_done pulses in the same cycle as output W*H-1.
- Gaps: in RUN, cycles with in_valid=0 stall everything with no state change and out_valid=0. Throughput is 1 pixel/clock.
- Output counters oc (column) and orow (row) track the centre pixel being emitted.
- Border masking: window positions outside the image are forced to 0.
  - Left column is forced to 0 when oc==0; right column when oc==W-1.
  - Top row is forced to 0 when orow==0; bottom row when orow==H-1.
  - No wrap-around between the end of one row and the start of the next.
- Output: out_pixel[i] = OR over enabled MASK positions of win_rc[i]. It is registered, so out_valid and out_pixel are aligned.
- Input size checks: img_width or img_height outside the legal range gives undefined output, but the state machine must still return to IDLE after W*H inputs plus W+1 flush cycles.
- Simultaneous events:
  - reset has priority over all activity.
  - in_valid asserted during FLUSH is not accepted, because in_ready=0; upstream holds the pixel.
  - The first pixel of the next frame is accepted in the cycle after FLUSH ends.

Decomposition:
- Shared image-processing package: state encoding (IDLE, RUN, FLUSH), the MASK bit-index constants, and the default MAX_WIDTH.
- One sub-module, line_buffer_n: a single-port-per-cycle delay RAM, depth MAX_WIDTH, N bits wide, with a programmable length W and advanced by an enable.
- Two instances of line_buffer_n plus a 3x3 shift-register window make up the datapath. The FSM, counters and masking live in the top module.

Test Plan:
- Centre dot: W=4, H=3, only (1,1)=1 → outputs at rows 0-2, columns 0-2 are 1, column 3 is 0; exactly 12 out_valid pulses; frame_done on the 12th.
- Corner and wrap: W=4, H=3, only (1,3)=1 → columns 2-3 of rows 0-2 are 1. Output (2,0) and (1,0) are 0, showing no row wrap. Repeat with (0,0)=1 → only (0,0), (0,1), (1,0), (1,1) are 1.
- Flush and backpressure: W=4, H=3, continuous input → in_ready low for exactly 5 cycles after the 12th accept. A held in_valid with the next frame's first pixel is accepted in the following cycle, and that frame is correct.
- Stalls: the centre-dot frame with in_valid toggling 1,0,0,1,... → output sequence identical to the continuous case; out_valid never asserted in a stall cycle during RUN.
- Mid-frame reset: an all-ones frame, reset after 6 pixels, then an all-zeros frame W=4, H=3 → out_valid=0 the cycle after reset; the second frame produces 12 zeros.
- Mask: MASK=9'h0BA (cross shape), W=5, H=5, only (2,2)=1 → ones only at (1,2), (2,1), (2,2), (2,3), (3,2).

Source files
------------

// File: rtl/dilation3x3_stream_pkg.sv
// -----------------------------------------------------------------------------
// dilation3x3_stream_pkg
//   Shared definitions for the streaming 3x3 binary dilation block.
//   - FSM state encoding (IDLE / RUN / FLUSH), exported on the debug port.
//   - Window position bit indices: bit (3*r + c) of a 9-bit mask refers to
//     window row r (0 = row above centre) and column c (0 = column left of
//     centre). K_11 is the centre.
//   - Default line-buffer depth.
//   - inside_mask(): builds the 9-bit set of window positions that lie inside
//     the image, from per-row and per-column "inside" flags.
// -----------------------------------------------------------------------------
package dilation3x3_stream_pkg;

   localparam int DEF_MAX_WIDTH = 640;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   localparam int K_00 = 0;
   localparam int K_01 = 1;
   localparam int K_02 = 2;
   localparam int K_10 = 3;
   localparam int K_11 = 4;
   localparam int K_12 = 5;
   localparam int K_20 = 6;
   localparam int K_21 = 7;
   localparam int K_22 = 8;

   // row_ok[r] / col_ok[c] say whether window row r / column c is inside the
   // image for the pixel currently being emitted.
   function automatic logic [8:0] inside_mask(input logic [2:0] row_ok,
                                              input logic [2:0] col_ok);
      logic [8:0] m;
      m       = '0;
      m[K_00] = row_ok[0] & col_ok[0];
      m[K_01] = row_ok[0] & col_ok[1];
      m[K_02] = row_ok[0] & col_ok[2];
      m[K_10] = row_ok[1] & col_ok[0];
      m[K_11] = row_ok[1] & col_ok[1];
      m[K_12] = row_ok[1] & col_ok[2];
      m[K_20] = row_ok[2] & col_ok[0];
      m[K_21] = row_ok[2] & col_ok[1];
      m[K_22] = row_ok[2] & col_ok[2];
      return m;
   endfunction

endpackage

// File: rtl/dilation3x3_stream_line_buffer.sv
// -----------------------------------------------------------------------------
// line_buffer_n
//   Programmable-length delay line built on a single RAM with one read and one
//   write to the same address per enabled cycle (read-before-write).
//   The read data is registered, so with length L the value on dout just
//   before enable k is the din presented at enable k-1-L. The caller therefore
//   programs L = (desired delay) - 1.
//
// Ports
//   clock  in   system clock
//   reset  in   synchronous active-high reset (clears pointer and dout only)
//   en     in   advance the delay line by one sample
//   start  in   first sample of a frame: use address 0 and restart the pointer
//   len    in   delay length L (1..MAX_WIDTH)
//   din    in   sample written on en
//   dout   out  registered read data
// -----------------------------------------------------------------------------
module line_buffer_n #(
   parameter int N         = 1,
   parameter int MAX_WIDTH = 640
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         en,
   input  logic         start,
   input  logic [15:0]  len,
   input  logic [N-1:0] din,
   output logic [N-1:0] dout
);

   localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(MAX_WIDTH - 1);

   logic [N-1:0]  mem [MAX_WIDTH];
   logic [AW-1:0] ptr;
   logic [AW-1:0] addr;
   logic [AW-1:0] addr_nxt;

   // Restarting at address 0 on the first sample of every frame keeps the
   // cycle length exactly L even when the previous frame used another width.
   assign addr = start ? '0 : ptr;

   // The extra guard on LAST_ADDR keeps the address in range when an illegal
   // length is programmed.
   always_comb begin
      addr_nxt = addr + AW'(1);
      if ((32'(addr) + 32'd1 >= 32'(len)) || (addr == LAST_ADDR)) begin
         addr_nxt = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ptr  <= '0;
         dout <= '0;
      end else if (en) begin
         ptr  <= addr_nxt;
         dout <= mem[addr];
      end
   end

   // Storage is not reset: stale contents only ever land in window positions
   // that the border masking forces to zero.
   always_ff @(posedge clock) begin
      if (en) begin
         mem[addr] <= din;
      end
   end

endmodule

// File: rtl/dilation3x3_stream.sv
// -----------------------------------------------------------------------------
// dilation3x3_stream
//   Streaming 3x3 morphological dilation of an N-bit-per-pixel binary image.
//   Each output bit is the OR of the enabled (MASK) positions of the 3x3
//   neighbourhood, with positions outside the image treated as zero.
//   Exactly img_width*img_height outputs per frame, in raster order.
//
// Ports
//   clock       in   system clock
//   reset       in   synchronous active-high reset
//   img_width   in   frame width (2..MAX_WIDTH), sampled on a frame's 1st pixel
//   img_height  in   frame height (>=2), sampled on a frame's 1st pixel
//   in_valid    in   input pixel present
//   in_ready    out  input accepted when in_valid && in_ready (low in FLUSH)
//   in_pixel    in   input pixel, raster order
//   out_valid   out  single-cycle output strobe
//   out_pixel   out  dilated pixel, aligned with out_valid
//   frame_done  out  pulses together with the last output of a frame
//   dbg_state   out  current FSM state (IDLE / RUN / FLUSH encoding)
//
// Handshake: a pixel transfers on a rising edge where in_valid and in_ready
// are both high; upstream must hold in_valid/in_pixel until then. The output
// side has no backpressure.
//
// Timing: every advance (accepted pixel, or one injected zero while flushing)
// shifts the window. The centre of the window is then pixel (step - W - 1),
// so output j leaves one cycle after step j+W+1. The flush injects W+1 zeros
// to push the last row through.
// -----------------------------------------------------------------------------
module dilation3x3_stream
   import dilation3x3_stream_pkg::*;
#(
   parameter int         N         = 1,
   parameter int         MAX_WIDTH = DEF_MAX_WIDTH,
   parameter logic [8:0] MASK      = 9'h1FF
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [15:0]  img_width,
   input  logic [15:0]  img_height,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_pixel,
   output logic         out_valid,
   output logic [N-1:0] out_pixel,
   output logic         frame_done,
   output logic [1:0]   dbg_state
);

   // ---------------------------------------------------------------- state
   logic [1:0]  state;
   logic [15:0] w_reg;
   logic [15:0] h_reg;
   logic [31:0] total_reg;   // W*H of the current frame
   logic [31:0] step_cnt;    // index of the next advance within the frame
   logic [15:0] oc;          // column of the pixel being emitted
   logic [15:0] orow;        // row of the pixel being emitted

   // ------------------------------------------------------------- controls
   logic         accept;
   logic         inject;
   logic         advance;
   logic         emit;
   logic         last_out;
   logic [15:0]  cur_w;
   logic [15:0]  lb_len;
   logic [31:0]  img_total;
   logic [N-1:0] pix_new;

   // ------------------------------------------------------------- datapath
   logic [N-1:0] lb1_q;
   logic [N-1:0] lb2_q;
   logic [N-1:0] win  [3][3];  // [row][col], row 0 = above centre
   logic [N-1:0] nwin [3][3];  // window after the current advance
   logic [2:0]   row_ok;
   logic [2:0]   col_ok;
   logic [8:0]   keep;
   logic [N-1:0] dil;

   assign in_ready  = (state != ST_FLUSH);
   assign dbg_state = state;
   assign accept    = in_valid && in_ready;
   assign inject    = (state == ST_FLUSH);
   assign advance   = accept || inject;
   assign pix_new   = inject ? '0 : in_pixel;

   // On the first pixel of a frame the width is not latched yet, so the line
   // buffers take it straight from the port.
   assign cur_w     = (state == ST_IDLE) ? img_width : w_reg;
   assign lb_len    = cur_w - 16'd1;
   assign img_total = 32'(img_width) * 32'(img_height);

   // The first W+1 advances of a frame only fill the window.
   assign emit      = advance && (state != ST_IDLE) &&
                      (step_cnt >= (32'(w_reg) + 32'd1));
   assign last_out  = (oc == w_reg - 16'd1) && (orow == h_reg - 16'd1);

   // ---------------------------------------------------------- line buffers
   // lb1 delays the incoming stream by one row, lb2 delays lb1 by another.
   line_buffer_n #(
      .N         (N),
      .MAX_WIDTH (MAX_WIDTH)
   ) u_lb1 (
      .clock (clock),
      .reset (reset),
      .en    (advance),
      .start (state == ST_IDLE),
      .len   (lb_len),
      .din   (pix_new),
      .dout  (lb1_q)
   );

   line_buffer_n #(
      .N         (N),
      .MAX_WIDTH (MAX_WIDTH)
   ) u_lb2 (
      .clock (clock),
      .reset (reset),
      .en    (advance),
      .start (state == ST_IDLE),
      .len   (lb_len),
      .din   (lb1_q),
      .dout  (lb2_q)
   );

   // ---------------------------------------------------------------- window
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         nwin[r][0] = win[r][1];
         nwin[r][1] = win[r][2];
      end
      nwin[0][2] = lb2_q;
      nwin[1][2] = lb1_q;
      nwin[2][2] = pix_new;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win[r][c] <= '0;
            end
         end
      end else if (advance) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win[r][c] <= nwin[r][c];
            end
         end
      end
   end

   // ------------------------------------------------------- border masking
   // Row/column flags for the pixel being emitted. Masking the right column
   // at oc==W-1 and the left column at oc==0 is what stops one row's edge
   // from bleeding into the next row.
   assign row_ok = {(orow != h_reg - 16'd1), 1'b1, (orow != 16'd0)};
   assign col_ok = {(oc   != w_reg - 16'd1), 1'b1, (oc   != 16'd0)};
   assign keep   = MASK & inside_mask(row_ok, col_ok);

   always_comb begin
      dil = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            if (keep[3*r + c]) begin
               dil = dil | nwin[r][c];
            end
         end
      end
   end

   // ------------------------------------------------------- FSM + counters
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ST_IDLE;
         w_reg      <= '0;
         h_reg      <= '0;
         total_reg  <= '0;
         step_cnt   <= '0;
         oc         <= '0;
         orow       <= '0;
         out_valid  <= 1'b0;
         out_pixel  <= '0;
         frame_done <= 1'b0;
      end else begin
         out_valid  <= emit;
         frame_done <= emit && last_out;

         if (emit) begin
            out_pixel <= dil;
            if (oc >= w_reg - 16'd1) begin
               oc   <= '0;
               orow <= orow + 16'd1;
            end else begin
               oc   <= oc + 16'd1;
            end
         end

         case (state)
            ST_IDLE: begin
               if (accept) begin
                  w_reg     <= img_width;
                  h_reg     <= img_height;
                  total_reg <= img_total;
                  step_cnt  <= 32'd1;
                  oc        <= '0;
                  orow      <= '0;
                  // A degenerate one-pixel frame is already complete.
                  state     <= (img_total <= 32'd1) ? ST_FLUSH : ST_RUN;
               end
            end
            ST_RUN: begin
               if (accept) begin
                  step_cnt <= step_cnt + 32'd1;
                  if (step_cnt + 32'd1 >= total_reg) begin
                     state <= ST_FLUSH;
                  end
               end
            end
            ST_FLUSH: begin
               // Flush steps are W*H .. W*H+W, i.e. W+1 injected zeros.
               if (step_cnt >= total_reg + 32'(w_reg)) begin
                  state    <= ST_IDLE;
                  step_cnt <= '0;
               end else begin
                  step_cnt <= step_cnt + 32'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dilation3x3_stream.sv
// -----------------------------------------------------------------------------
// tb_dilation3x3_stream
//   Two instances share all inputs: dut_a uses the full 3x3 element, dut_b a
//   cross-shaped element. A reference model computes every expected output
//   directly from the frame contents (neighbourhood OR with zero padding) and
//   queues {frame_done, pixel} per instance; a monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_dilation3x3_stream;
   import dilation3x3_stream_pkg::*;

   localparam int         N       = 1;
   localparam logic [8:0] MASK_A  = 9'h1FF;
   localparam logic [8:0] MASK_B  = 9'h0BA;
   localparam int         FRM_MAX = 2048;

   // ------------------------------------------------------ clock and reset
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic [15:0]  img_width  = 16'd4;
   logic [15:0]  img_height = 16'd3;
   logic         in_valid   = 1'b0;
   logic [N-1:0] in_pixel   = '0;

   logic         in_ready_a, out_valid_a, frame_done_a;
   logic [N-1:0] out_pixel_a;
   logic [1:0]   dbg_state_a;
   logic         in_ready_b, out_valid_b, frame_done_b;
   logic [N-1:0] out_pixel_b;
   logic [1:0]   dbg_state_b;

   dilation3x3_stream #(.N(N), .MASK(MASK_A)) dut_a (
      .clock(clock), .reset(reset), .img_width(img_width), .img_height(img_height),
      .in_valid(in_valid), .in_ready(in_ready_a), .in_pixel(in_pixel),
      .out_valid(out_valid_a), .out_pixel(out_pixel_a), .frame_done(frame_done_a),
      .dbg_state(dbg_state_a)
   );

   dilation3x3_stream #(.N(N), .MASK(MASK_B)) dut_b (
      .clock(clock), .reset(reset), .img_width(img_width), .img_height(img_height),
      .in_valid(in_valid), .in_ready(in_ready_b), .in_pixel(in_pixel),
      .out_valid(out_valid_b), .out_pixel(out_pixel_b), .frame_done(frame_done_b),
      .dbg_state(dbg_state_b)
   );

   // ------------------------------------------------------------ scoreboard
   int         total = 0;
   int         bad   = 0;
   int         out_cnt_a = 0;
   logic [1:0] exp_a_q[$];
   logic [1:0] exp_b_q[$];
   logic       frm [FRM_MAX];

   // Reference: OR of all in-image neighbours selected by the element.
   function automatic logic model_pix(input int w, input int h, input logic [8:0] m,
                                      input int r, input int c);
      logic acc;
      int   rr, cc;
      acc = 1'b0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (m[3*(dr+1) + (dc+1)] && rr >= 0 && rr < h && cc >= 0 && cc < w)
               acc = acc | frm[rr*w + cc];
         end
      end
      return acc;
   endfunction

   task automatic model_frame(input int w, input int h);
      logic done;
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            done = (r == h-1) && (c == w-1);
            exp_a_q.push_back({done, model_pix(w, h, MASK_A, r, c)});
            exp_b_q.push_back({done, model_pix(w, h, MASK_B, r, c)});
         end
      end
   endtask

   task automatic clear_frm();
      for (int i = 0; i < FRM_MAX; i++) frm[i] = 1'b0;
   endtask

   task automatic run_monitor();
      logic [1:0] e;
      forever begin
         @(negedge clock);
         if (out_valid_a === 1'b1) begin
            out_cnt_a++;
            total++;
            if (exp_a_q.size() == 0) begin
               bad++;
               $display("FAIL out_a_extra: got pix=%0b done=%0b, required no output",
                        out_pixel_a, frame_done_a);
            end else begin
               e = exp_a_q.pop_front();
               if ({frame_done_a, out_pixel_a} !== e) begin
                  bad++;
                  $display("FAIL out_a: got done=%0b pix=%0b, required done=%0b pix=%0b",
                           frame_done_a, out_pixel_a, e[1], e[0]);
               end
            end
         end else if (frame_done_a === 1'b1) begin
            total++;
            bad++;
            $display("FAIL done_a_alone: got frame_done=1 with out_valid=0, required 0");
         end
         if (out_valid_b === 1'b1) begin
            total++;
            if (exp_b_q.size() == 0) begin
               bad++;
               $display("FAIL out_b_extra: got pix=%0b done=%0b, required no output",
                        out_pixel_b, frame_done_b);
            end else begin
               e = exp_b_q.pop_front();
               if ({frame_done_b, out_pixel_b} !== e) begin
                  bad++;
                  $display("FAIL out_b: got done=%0b pix=%0b, required done=%0b pix=%0b",
                           frame_done_b, out_pixel_b, e[1], e[0]);
               end
            end
         end else if (frame_done_b === 1'b1) begin
            total++;
            bad++;
            $display("FAIL done_b_alone: got frame_done=1 with out_valid=0, required 0");
         end
      end
   endtask

   // ---------------------------------------------------------- driver tasks
   task automatic push_pixel(input logic [N-1:0] p);
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      in_pixel = p;
      while (in_ready_a !== 1'b1 && guard < 200) begin
         @(posedge clock); #1;
         guard++;
      end
      if (guard >= 200) begin
         total++;
         bad++;
         $display("FAIL in_ready_timeout: got in_ready=%0b for 200 cycles, required 1", in_ready_a);
      end
      @(posedge clock); #1;
      in_valid = 1'b0;
   endtask

   // One stalled cycle inside RUN: no output may appear after it.
   task automatic idle_cycle();
      in_valid = 1'b0;
      @(posedge clock); #1;
      total++;
      if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin
         bad++;
         $display("FAIL stall_out_valid: got a=%0b b=%0b, required 0 0", out_valid_a, out_valid_b);
      end
   endtask

   // mode 0: continuous, 1: two idle cycles between pixels, 2: random gaps
   task automatic send_frame(input int w, input int h, input int mode);
      int n;
      img_width  = 16'(w);
      img_height = 16'(h);
      for (int i = 0; i < w*h; i++) begin
         push_pixel(frm[i]);
         if (i != w*h-1) begin
            n = (mode == 0) ? 0 : (mode == 1) ? 2 : int'($urandom_range(0, 2));
            repeat (n) idle_cycle();
         end
      end
   endtask

   task automatic wait_drain(input string name);
      int g;
      g = 0;
      while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && g < 3000) begin
         @(posedge clock);
         g++;
      end
      repeat (2) @(posedge clock);
      #1;
      total++;
      if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
         bad++;
         $display("FAIL %s_drain: got %0d/%0d outputs outstanding, required 0/0",
                  name, exp_a_q.size(), exp_b_q.size());
         exp_a_q.delete();
         exp_b_q.delete();
      end
      total++;
      if (dbg_state_a !== ST_IDLE || dbg_state_b !== ST_IDLE) begin
         bad++;
         $display("FAIL %s_idle: got state a=%0d b=%0d, required %0d",
                  name, dbg_state_a, dbg_state_b, ST_IDLE);
      end
   endtask

   // ----------------------------------------------------------------- tests
   task automatic test_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      total++;
      if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin
         bad++;
         $display("FAIL reset_in_ready: got a=%0b b=%0b, required 1", in_ready_a, in_ready_b);
      end
      total++;
      if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin
         bad++;
         $display("FAIL reset_out_valid: got a=%0b b=%0b, required 0", out_valid_a, out_valid_b);
      end
      total++;
      if (out_pixel_a !== '0 || out_pixel_b !== '0) begin
         bad++;
         $display("FAIL reset_out_pixel: got a=%0b b=%0b, required 0", out_pixel_a, out_pixel_b);
      end
      total++;
      if (frame_done_a !== 1'b0 || frame_done_b !== 1'b0) begin
         bad++;
         $display("FAIL reset_frame_done: got a=%0b b=%0b, required 0", frame_done_a, frame_done_b);
      end
      total++;
      if (dbg_state_a !== ST_IDLE) begin
         bad++;
         $display("FAIL reset_state: got %0d, required %0d", dbg_state_a, ST_IDLE);
      end
      reset = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic test_centre_dot();
      clear_frm();
      frm[1*4 + 1] = 1'b1;
      model_frame(4, 3);
      out_cnt_a = 0;
      send_frame(4, 3, 0);
      wait_drain("centre_dot");
      total++;
      if (out_cnt_a != 12) begin
         bad++;
         $display("FAIL centre_dot_count: got %0d outputs, required 12", out_cnt_a);
      end
   endtask

   task automatic test_corner_wrap();
      clear_frm();
      frm[1*4 + 3] = 1'b1;
      model_frame(4, 3);
      send_frame(4, 3, 0);
      wait_drain("corner_right");
      clear_frm();
      frm[0] = 1'b1;
      model_frame(4, 3);
      send_frame(4, 3, 0);
      wait_drain("corner_origin");
   endtask

   task automatic test_stalls();
      clear_frm();
      frm[1*4 + 1] = 1'b1;
      model_frame(4, 3);
      out_cnt_a = 0;
      send_frame(4, 3, 1);
      wait_drain("stalls");
      total++;
      if (out_cnt_a != 12) begin
         bad++;
         $display("FAIL stalls_count: got %0d outputs, required 12", out_cnt_a);
      end
   endtask

   task automatic test_flush_backpressure();
      int low;
      clear_frm();
      for (int i = 0; i < 12; i++) frm[i] = 1'($urandom_range(0, 1));
      model_frame(4, 3);
      send_frame(4, 3, 0);
      // Next frame's first pixel is held while the block flushes.
      clear_frm();
      for (int i = 0; i < 12; i++) frm[i] = 1'($urandom_range(0, 1));
      frm[0] = 1'b1;
      model_frame(4, 3);
      img_width  = 16'd4;
      img_height = 16'd3;
      in_valid   = 1'b1;
      in_pixel   = frm[0];
      low = 0;
      while (in_ready_a !== 1'b1 && low < 20) begin
         @(posedge clock); #1;
         low++;
      end
      total++;
      if (low != 5) begin
         bad++;
         $display("FAIL flush_ready_low: got %0d cycles, required 5", low);
      end
      send_frame(4, 3, 0);
      wait_drain("flush_next");
   endtask

   task automatic test_midframe_reset();
      clear_frm();
      for (int i = 0; i < 12; i++) frm[i] = 1'b1;
      // Six pixels emit only output (0,0) before the abort.
      exp_a_q.push_back({1'b0, model_pix(4, 3, MASK_A, 0, 0)});
      exp_b_q.push_back({1'b0, model_pix(4, 3, MASK_B, 0, 0)});
      img_width  = 16'd4;
      img_height = 16'd3;
      for (int i = 0; i < 6; i++) push_pixel(frm[i]);
      reset = 1'b1;
      @(posedge clock); #1;
      total++;
      if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin
         bad++;
         $display("FAIL abort_out_valid: got a=%0b b=%0b, required 0", out_valid_a, out_valid_b);
      end
      total++;
      if (in_ready_a !== 1'b1 || dbg_state_a !== ST_IDLE) begin
         bad++;
         $display("FAIL abort_state: got ready=%0b state=%0d, required 1 %0d",
                  in_ready_a, dbg_state_a, ST_IDLE);
      end
      total++;
      if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
         bad++;
         $display("FAIL abort_pending: got %0d/%0d outstanding, required 0/0",
                  exp_a_q.size(), exp_b_q.size());
         exp_a_q.delete();
         exp_b_q.delete();
      end
      reset = 1'b0;
      @(posedge clock); #1;
      clear_frm();
      model_frame(4, 3);
      send_frame(4, 3, 0);
      wait_drain("after_abort");
   endtask

   task automatic test_mask();
      clear_frm();
      frm[2*5 + 2] = 1'b1;
      model_frame(5, 5);
      send_frame(5, 5, 0);
      wait_drain("mask_cross");
   endtask

   task automatic test_random();
      int w, h;
      for (int f = 0; f < 4; f++) begin
         w = int'($urandom_range(2, 8));
         h = int'($urandom_range(2, 6));
         clear_frm();
         for (int i = 0; i < w*h; i++) frm[i] = ($urandom_range(0, 3) == 0);
         model_frame(w, h);
         send_frame(w, h, 2);
      end
      clear_frm();
      for (int i = 0; i < 4; i++) frm[i] = 1'($urandom_range(0, 1));
      model_frame(2, 2);
      send_frame(2, 2, 0);
      clear_frm();
      for (int i = 0; i < DEF_MAX_WIDTH*2; i++) frm[i] = ($urandom_range(0, 7) == 0);
      model_frame(DEF_MAX_WIDTH, 2);
      send_frame(DEF_MAX_WIDTH, 2, 0);
      wait_drain("random");
   endtask

   // ------------------------------------------------------------- sequence
   initial begin
      clear_frm();
      fork
         run_monitor();
      join_none
      test_reset();
      test_centre_dot();
      test_corner_wrap();
      test_stalls();
      test_flush_backpressure();
      test_midframe_reset();
      test_mask();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
